// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and helpers for the multi-port FIFO
package fifo_pkg;

    localparam int MAX_LANES  = 4;
    localparam int LANE_CNT_W = $clog2(MAX_LANES + 1);
    localparam int LANE_IDX_W = $clog2(MAX_LANES);

    function automatic logic [LANE_CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [LANE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + LANE_CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/fifo_lane_pack.sv
// rtl/fifo_lane_pack.sv - compacts sparse push lanes into consecutive slot offsets
module fifo_lane_pack
    import fifo_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]                 push_i,
    output logic [LANE_CNT_W-1:0]            n_push_o,
    output logic [LANES-1:0][LANE_IDX_W-1:0] offset_o
);

    logic [LANE_CNT_W-1:0] run;

    // Each active lane lands at the number of active lanes below it.
    always_comb begin
        run      = '0;
        offset_o = '0;
        for (int i = 0; i < LANES; i++) begin
            offset_o[i] = run[LANE_IDX_W-1:0];
            run         = run + LANE_CNT_W'(push_i[i]);
        end
        n_push_o = popcount(MAX_LANES'(push_i));
    end

endmodule

// File: rtl/multi_port_fifo.sv
// rtl/multi_port_fifo.sv - multi-lane push / multi-lane pop FIFO with registered read lanes
// Optional sticky overflow/underflow outputs when MULTI_PORT_FIFO_ERR_EN is defined.
module multi_port_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int PUSH_PORTS  = 2,
    parameter int POP_PORTS   = 2,
    parameter int AFULL_LEVEL = (2 ** ADDR_WIDTH) - 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PUSH_PORTS-1:0]              push,
    input  logic [PUSH_PORTS*DATA_WIDTH-1:0]   data_in,
    output logic                               push_ok,
    input  logic [$clog2(POP_PORTS+1)-1:0]     pop_cnt,
    output logic [POP_PORTS*DATA_WIDTH-1:0]    data_out,
    output logic [POP_PORTS-1:0]               data_valid,
    output logic [ADDR_WIDTH:0]                count,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_full
`ifdef MULTI_PORT_FIFO_ERR_EN
    ,
    output logic                               overflow,
    output logic                               underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]                 mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                         count_q, count_d;
    logic [POP_PORTS*DATA_WIDTH-1:0]       dout_q, dout_d;
    logic [POP_PORTS-1:0]                  valid_q, valid_d;
    logic [LANE_CNT_W-1:0]                 n_push;
    logic [PUSH_PORTS-1:0][LANE_IDX_W-1:0] offset;
    int                                    np;

    fifo_lane_pack #(.LANES(PUSH_PORTS)) u_lane_pack (
        .push_i   (push),
        .n_push_o (n_push),
        .offset_o (offset)
    );

    // Acceptance only looks at current occupancy; a same-cycle pop does not make room.
    always_comb begin
        push_ok  = int'(n_push) <= (DEPTH - int'(count_q));
        np       = int'(pop_cnt);
        if (np > int'(count_q)) np = int'(count_q);
        if (np > POP_PORTS)     np = POP_PORTS;
        count_d  = count_q + (push_ok ? CW'(n_push) : CW'(0)) - CW'(np);
        wr_ptr_d = wr_ptr_q + (push_ok ? ADDR_WIDTH'(n_push) : ADDR_WIDTH'(0));
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(np);
        dout_d   = '0;
        valid_d  = '0;
        for (int j = 0; j < POP_PORTS; j++) begin
            if (j < np) begin
                valid_d[j] = 1'b1;
                dout_d[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = mem_q[rd_ptr_q + ADDR_WIDTH'(j)];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_PORTS; i++) begin
            if (!reset && push_ok && push[i]) begin
                mem_q[wr_ptr_q + ADDR_WIDTH'(offset[i])] <= data_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

`ifdef MULTI_PORT_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if ((|push) && !push_ok)             overflow_q  <= 1'b1;
            if (int'(pop_cnt) > int'(count_q))   underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = int'(count_q) >= AFULL_LEVEL;

endmodule

// File: tb/tb_multi_port_fifo.sv
// tb/tb_multi_port_fifo.sv - randomized bench for multi_port_fifo against a queue model
module tb_multi_port_fifo;

    localparam int DW    = 32;
    localparam int PP    = 2;
    localparam int OP    = 2;
    localparam int DEPTH = 32;
    localparam int AFL   = DEPTH - 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  push;
    logic [63:0] data_in;
    logic        push_ok;
    logic [1:0]  pop_cnt;
    logic [63:0] data_out;
    logic [1:0]  data_valid;
    logic [5:0]  count;
    logic        empty, full, almost_full;
`ifdef MULTI_PORT_FIFO_ERR_EN
    logic        overflow, underflow;
`endif

    multi_port_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .data_in     (data_in),
        .push_ok     (push_ok),
        .pop_cnt     (pop_cnt),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
`ifdef MULTI_PORT_FIFO_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mq[$];
    logic [63:0] exp_dout;
    logic [1:0]  exp_valid;
    bit          exp_ovf, exp_unf;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        check_val("count", 64'(count), 64'(sz));
        check_val("empty", 64'(empty), 64'(sz == 0));
        check_val("full", 64'(full), 64'(sz == DEPTH));
        check_val("almost_full", 64'(almost_full), 64'(sz >= AFL));
        check_val("data_valid", 64'(data_valid), 64'(exp_valid));
        check_val("data_out", data_out, exp_dout);
`ifdef MULTI_PORT_FIFO_ERR_EN
        check_val("overflow", 64'(overflow), 64'(exp_ovf));
        check_val("underflow", 64'(underflow), 64'(exp_unf));
`endif
    endtask

    task automatic cycle(input logic [1:0] p, input logic [63:0] d, input logic [1:0] pc);
        int sz, npush, np;
        bit ok;
        @(negedge clk);
        push = p; data_in = d; pop_cnt = pc;
        #1;
        sz    = mq.size();
        npush = int'(p[0]) + int'(p[1]);
        ok    = npush <= (DEPTH - sz);
        check_val("push_ok", 64'(push_ok), 64'(ok));
        np = int'(pc);
        if (np > sz) np = sz;
        if (np > OP) np = OP;
        if (p != 2'b00 && !ok) exp_ovf = 1'b1;
        if (int'(pc) > sz)     exp_unf = 1'b1;
        exp_dout  = '0;
        exp_valid = '0;
        for (int j = 0; j < np; j++) begin
            exp_dout[j*DW +: DW] = mq.pop_front();
            exp_valid[j] = 1'b1;
        end
        if (ok) begin
            for (int i = 0; i < PP; i++) begin
                if (p[i]) mq.push_back(d[i*DW +: DW]);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        push = '0; pop_cnt = '0;
    endtask

    task automatic model_clear();
        mq.delete();
        exp_dout  = '0;
        exp_valid = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("reset_count", 64'(count), 64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        reset = 1'b1; push = 2'b11; data_in = rnd64(); pop_cnt = 2'd2;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check_val("push_ok_in_reset", 64'(push_ok), 64'd1);
        @(negedge clk);
        reset = 1'b0; push = '0; pop_cnt = '0;
        #1;
        check_outputs();

        // two-lane push then two-lane pop, valid clears afterwards
        cycle(2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 2'd0);
        cycle(2'b00, 64'd0, 2'd2);
        cycle(2'b00, 64'd0, 2'd0);

        // sparse push packs lane1 into the next slot
        cycle(2'b10, {32'hCCCC_0003, 32'hDEAD_BEEF}, 2'd0);
        cycle(2'b00, 64'd0, 2'd1);

        // fill to DEPTH-1, rejected double push, then single push fills
        do_reset();
        repeat (15) cycle(2'b11, rnd64(), 2'd0);
        cycle(2'b01, rnd64(), 2'd0);
        cycle(2'b11, rnd64(), 2'd0);
        cycle(2'b01, rnd64(), 2'd0);
        cycle(2'b11, rnd64(), 2'd3);

        // short pop on a single entry
        do_reset();
        cycle(2'b01, rnd64(), 2'd0);
        cycle(2'b00, 64'd0, 2'd2);

        // write pointer at the last slot, double push straddles the wrap
        do_reset();
        cycle(2'b01, rnd64(), 2'd0);
        repeat (30) cycle(2'b01, rnd64(), 2'd1);
        cycle(2'b11, rnd64(), 2'd1);
        cycle(2'b00, 64'd0, 2'd2);
        cycle(2'b00, 64'd0, 2'd2);

        // asynchronous reset with count=10 and live read lanes
        do_reset();
        repeat (5) cycle(2'b11, rnd64(), 2'd0);
        cycle(2'b01, rnd64(), 2'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_count", 64'(count), 64'd0);
        check_val("async_valid", 64'(data_valid), 64'd0);
        check_val("async_dout", data_out, 64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs();

        // random traffic: fill-biased, balanced, drain-biased phases
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 200; k++) begin
                logic [1:0] p, pc;
                p  = 2'($urandom_range(0, 3));
                pc = 2'($urandom_range(0, 3));
                if (ph == 0 && $urandom_range(0, 2) != 0) pc = 2'd0;
                if (ph == 2 && $urandom_range(0, 2) != 0) p  = 2'b00;
                cycle(p, rnd64(), pc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_port_fifo.md
MULTI_PORT_FIFO -- requirements
Module: multi_port_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter PUSH_PORTS, default 2, write lanes (1..4).
REQ-004 SHALL have parameter POP_PORTS, default 2, read lanes (1..4).
REQ-005 SHALL have parameter AFULL_LEVEL, default DEPTH-4, almost_full threshold.
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port push, input, PUSH_PORTS, per-lane write request.
REQ-009 SHALL have port data_in, input, PUSH_PORTS*DATA_WIDTH, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port push_ok, output, 1, combinational: this cycle's push set is accepted.
REQ-011 SHALL have port pop_cnt, input, $clog2(POP_PORTS+1), entries requested this cycle.
REQ-012 SHALL have port data_out, output, POP_PORTS*DATA_WIDTH, registered read lanes.
REQ-013 SHALL have port data_valid, output, POP_PORTS, registered per-lane valid.
REQ-014 SHALL have port count, output, ADDR_WIDTH+1, registered occupancy.
REQ-015 SHALL have ports empty, full and almost_full, each output, 1, decoded from count.

Function
REQ-016 SHALL define full as count==DEPTH and empty as count==0; all DEPTH entries are usable.
REQ-017 SHALL define almost_full as count>=AFULL_LEVEL.
REQ-018 SHALL compute n_push as the popcount of push; push_ok=1 iff n_push <= DEPTH-count. Space freed by a same-cycle pop is not credited.
REQ-019 SHALL make push acceptance all-or-nothing: push_ok=0 writes no lane.
REQ-020 SHALL pack accepted lanes in ascending lane index into consecutive slots from wr_ptr; gaps in the push vector are skipped.
REQ-021 SHALL compute n_pop = min(pop_cnt, count, POP_PORTS); pops never underflow.
REQ-022 SHALL, one cycle after a pop, present the oldest n_pop entries on data_out lanes 0..n_pop-1 with data_valid set; the remaining lanes SHALL have data_valid=0 and data_out=0.
REQ-023 SHALL clear data_valid in any cycle following a cycle with n_pop=0.
REQ-024 SHALL update count <= count + (push_ok ? n_push : 0) - n_pop every cycle.
REQ-025 SHALL wrap wr_ptr and rd_ptr modulo DEPTH; a multi-lane access straddling the end SHALL wrap per lane.
REQ-026 SHALL base pop eligibility on pre-edge count: data pushed in cycle t is poppable from t+1. No write-to-read bypass.

Reset
REQ-027 SHALL, while reset=1, asynchronously clear wr_ptr, rd_ptr, count, data_out and data_valid.
REQ-028 SHALL leave storage contents uninitialised on reset; entries are unreadable until written.
REQ-029 SHALL give the following values after reset: empty=1, full=0, almost_full=0 (or 1 if AFULL_LEVEL==0), push_ok=1 for n_push<=DEPTH.
REQ-030 SHALL abandon any push or pop in the reset cycle; no partial update.

Configuration
REQ-031 SHALL, with macro MULTI_PORT_FIFO_ERR_EN defined, add outputs overflow and underflow (1 bit each). These are sticky flags set on rejected pushes (push!=0 with push_ok=0) and on short pops (pop_cnt>count), and cleared only by reset.
REQ-032 SHALL, without MULTI_PORT_FIFO_ERR_EN, omit both ports and their logic entirely.

Structure
REQ-033 SHALL place in shared package fifo_pkg the popcount function, the clog2-based width localparams, and the lane slice helper.
REQ-034 SHALL instantiate one sub-module fifo_lane_pack, a combinational compaction of sparse push lanes to packed slot offsets. The storage array and control SHALL remain in multi_port_fifo.

Verification
REQ-035 SHALL cover: after reset, push=2'b11, data_in {B,A} -> count=2; pop_cnt=2 next cycle -> one cycle later data_out lane0=A, lane1=B, data_valid=2'b11.
REQ-036 SHALL cover: push=2'b10 with data lane1=C on an empty FIFO -> C stored at slot 0; pop_cnt=1 -> lane0=C, data_valid=2'b01.
REQ-037 SHALL cover: fill to count=31 (DEPTH=32), then push=2'b11 -> push_ok=0, count stays 31; with ERR_EN, overflow=1. Then push=2'b01 -> full=1.
REQ-038 SHALL cover: count=1 and pop_cnt=2 -> data_valid=2'b01, count=0, empty=1; with ERR_EN, underflow=1.
REQ-039 SHALL cover: wr_ptr=31, push=2'b11 -> entries written at slots 31 and 0; a subsequent pop returns them in order.
REQ-040 SHALL cover: reset asserted mid-stream with count=10 -> count=0, data_valid=0 asynchronously, before the next clock edge.
